fp_mul_pipe: RTL and testbench

- Pipelined IEEE-754 multiplier for half (binary16) and single (binary32), mode selectable per transaction.
- Successor to the combinational FP multiply datapath. Adds a valid/ready handshake, a 3-stage pipeline with full-pipe stall, normalisation, rounding, special-value handling, IEEE-style exception flags and a packed result.
- Sits between the operand issue logic and the FP writeback path.

---
 rtl/fp_mul_pipe_if.sv | 23 ++
 rtl/fp_mul_pipe.sv | 259 +++++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// Valid/ready operand and result bundle for fp_mul_pipe.
interface fp_mul_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        out_mode;

  modport slave (
    input  in_valid, in_mode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_mode
  );

  modport master (
    output in_valid, in_mode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_mode
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Pipelined binary16/binary32 multiplier: operand capture, unpack/multiply, normalise, round/pack.
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even, otherwise round toward zero.
module fp_mul_pipe #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned FTZ     = 1
) (
  input  logic        clk,
  input  logic        rst,
  fp_mul_pipe_if.slave bus
);

  localparam int unsigned EW = 10;

  generate
    if (LATENCY != 3) begin : g_lat_chk
      $error("fp_mul_pipe: only LATENCY = 3 is supported");
    end
    if (FTZ != 1) begin : g_ftz_chk
      $error("fp_mul_pipe: only FTZ = 1 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_e;

  typedef struct packed {
    logic        vld;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct packed {
    logic             vld;
    logic             mode;
    logic             sign;
    kind_e            kind;
    logic             invalid;
    logic signed [9:0] exp;
    logic [47:0]      prod;
  } s1_t;

  typedef struct packed {
    logic             vld;
    logic             mode;
    logic             sign;
    kind_e            kind;
    logic             invalid;
    logic signed [9:0] exp;
    logic [22:0]      frac;
    logic             g;
    logic             r;
    logic             s;
  } s2_t;

  typedef struct packed {
    logic        vld;
    logic        mode;
    logic [31:0] result;
    logic [4:0]  flags;
  } out_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } unpk_t;

  op_t  op_q,  op_d;
  s1_t  s1_q,  s1_d;
  s2_t  s2_q,  s2_d;
  out_t out_q, out_d;

  logic adv_c;

  // Half fractions are left-aligned so both formats share one datapath.
  function automatic unpk_t unpack(input logic mode, input logic [31:0] x);
    unpk_t u;
    if (mode) begin
      u.sign = x[31];
      u.exp  = x[30:23];
      u.frac = x[22:0];
    end else begin
      u.sign = x[15];
      u.exp  = {3'b000, x[14:10]};
      u.frac = {x[9:0], 13'b0};
    end
    return u;
  endfunction

  assign adv_c         = !out_q.vld || bus.out_ready;
  assign bus.in_ready  = adv_c;
  assign bus.out_valid = out_q.vld;
  assign bus.out_mode  = out_q.mode;
  assign bus.out_result = out_q.result;
  assign bus.out_flags = out_q.flags;

  // Operand capture
  always_comb begin
    op_d = op_q;
    if (adv_c) begin
      op_d.vld  = bus.in_valid;
      op_d.mode = bus.in_mode;
      op_d.a    = bus.in_a;
      op_d.b    = bus.in_b;
    end
  end

  // Stage 1: classify, exponent sum, significand product
  unpk_t ua, ub;
  logic [7:0] emax;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

  always_comb begin
    s1_d   = s1_q;
    ua     = unpack(op_q.mode, op_q.a);
    ub     = unpack(op_q.mode, op_q.b);
    emax   = op_q.mode ? 8'hFF : 8'h1F;
    zero_a = (ua.exp == 8'h00);
    zero_b = (ub.exp == 8'h00);
    inf_a  = (ua.exp == emax) && (ua.frac == 23'h0);
    inf_b  = (ub.exp == emax) && (ub.frac == 23'h0);
    nan_a  = (ua.exp == emax) && (ua.frac != 23'h0);
    nan_b  = (ub.exp == emax) && (ub.frac != 23'h0);
    snan_a = nan_a && !ua.frac[22];
    snan_b = nan_b && !ub.frac[22];
    if (adv_c) begin
      s1_d.vld     = op_q.vld;
      s1_d.mode    = op_q.mode;
      s1_d.sign    = ua.sign ^ ub.sign;
      s1_d.exp     = EW'(ua.exp) + EW'(ub.exp) - (op_q.mode ? EW'(127) : EW'(15));
      s1_d.prod    = 48'({1'b1, ua.frac}) * 48'({1'b1, ub.frac});
      s1_d.invalid = 1'b0;
      if (nan_a || nan_b) begin
        s1_d.kind    = K_NAN;
        s1_d.invalid = snan_a || snan_b;
      end else if ((zero_a && inf_b) || (inf_a && zero_b)) begin
        s1_d.kind    = K_NAN;
        s1_d.invalid = 1'b1;
      end else if (inf_a || inf_b) begin
        s1_d.kind = K_INF;
      end else if (zero_a || zero_b) begin
        s1_d.kind = K_ZERO;
      end else begin
        s1_d.kind = K_NORM;
      end
    end
  end

  // Stage 2: normalise and extract fraction/guard/round/sticky
  logic        shift;
  logic        drop;
  logic [45:0] norm;

  always_comb begin
    s2_d  = s2_q;
    shift = s1_q.prod[47];
    norm  = shift ? s1_q.prod[46:1] : s1_q.prod[45:0];
    drop  = shift & s1_q.prod[0];
    if (adv_c) begin
      s2_d.vld     = s1_q.vld;
      s2_d.mode    = s1_q.mode;
      s2_d.sign    = s1_q.sign;
      s2_d.kind    = s1_q.kind;
      s2_d.invalid = s1_q.invalid;
      s2_d.exp     = s1_q.exp + EW'(shift);
      if (s1_q.mode) begin
        s2_d.frac = norm[45:23];
        s2_d.g    = norm[22];
        s2_d.r    = norm[21];
        s2_d.s    = (|norm[20:0]) | drop;
      end else begin
        s2_d.frac = {13'b0, norm[45:36]};
        s2_d.g    = norm[35];
        s2_d.r    = norm[34];
        s2_d.s    = (|norm[33:0]) | drop;
      end
    end
  end

  // Stage 3: round, resolve specials, pack
  logic              round_up;
  logic [23:0]       frac_r;
  logic              carry;
  logic [22:0]       frac_f;
  logic signed [9:0] exp_f;
  logic signed [9:0] emax_f;
  logic              inexact;
  logic [31:0]       res_c;
  logic [4:0]        flg_c;

  always_comb begin
    out_d = out_q;
`ifdef FP_MUL_RNE_EN
    round_up = s2_q.g & (s2_q.r | s2_q.s | s2_q.frac[0]);
`else
    round_up = 1'b0;
`endif
    frac_r  = {1'b0, s2_q.frac} + 24'(round_up);
    carry   = s2_q.mode ? frac_r[23] : frac_r[10];
    exp_f   = s2_q.exp + EW'(carry);
    frac_f  = carry ? 23'h0 : frac_r[22:0];
    emax_f  = s2_q.mode ? 10'sd255 : 10'sd31;
    inexact = s2_q.g | s2_q.r | s2_q.s;
    res_c   = 32'h0;
    flg_c   = 5'b00000;
    case (s2_q.kind)
      K_NAN: begin
        res_c = s2_q.mode ? 32'h7FC0_0000 : 32'h0000_7E00;
        flg_c = {s2_q.invalid, 3'b000, 1'b1};
      end
      K_INF: begin
        res_c = s2_q.mode ? {s2_q.sign, 8'hFF, 23'h0} : {16'h0, s2_q.sign, 5'h1F, 10'h0};
      end
      K_ZERO: begin
        res_c = s2_q.mode ? {s2_q.sign, 31'h0} : {16'h0, s2_q.sign, 15'h0};
      end
      default: begin
        if (exp_f >= emax_f) begin
`ifdef FP_MUL_RNE_EN
          res_c = s2_q.mode ? {s2_q.sign, 8'hFF, 23'h0} : {16'h0, s2_q.sign, 5'h1F, 10'h0};
`else
          res_c = s2_q.mode ? {s2_q.sign, 8'hFE, 23'h7FFFFF} : {16'h0, s2_q.sign, 5'h1E, 10'h3FF};
`endif
          flg_c = 5'b01010;
        end else if (exp_f <= 10'sd0) begin
          res_c = s2_q.mode ? {s2_q.sign, 31'h0} : {16'h0, s2_q.sign, 15'h0};
          flg_c = 5'b00110;
        end else begin
          res_c = s2_q.mode ? {s2_q.sign, exp_f[7:0], frac_f}
                            : {16'h0, s2_q.sign, exp_f[4:0], frac_f[9:0]};
          flg_c = {3'b000, inexact, 1'b0};
        end
      end
    endcase
    if (adv_c) begin
      out_d.vld = s2_q.vld;
      if (s2_q.vld) begin
        out_d.mode   = s2_q.mode;
        out_d.result = res_c;
        out_d.flags  = flg_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
    end else begin
      op_q  <= op_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed scoreboard bench for fp_mul_pipe (expectations follow FP_MUL_RNE_EN when defined).
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_mul_pipe_if bus ();

  fp_mul_pipe #(.LATENCY(3), .FTZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FP_MUL_RNE_EN
  localparam logic [31:0] E_RND_S = 32'h3FC0_0002;
  localparam logic [31:0] E_OVF_S = 32'h7F80_0000;
  localparam logic [31:0] E_RND_H = 32'h0000_3E02;
  localparam logic [31:0] E_OVF_H = 32'h0000_7C00;
`else
  localparam logic [31:0] E_RND_S = 32'h3FC0_0001;
  localparam logic [31:0] E_OVF_S = 32'h7F7F_FFFF;
  localparam logic [31:0] E_RND_H = 32'h0000_3E01;
  localparam logic [31:0] E_OVF_H = 32'h0000_7BFF;
`endif

  typedef struct {
    bit          mode;
    logic [31:0] res;
    logic [4:0]  fl;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          stall_from = 0;
  int          stall_len  = 0;
  bit          held     = 1'b0;
  bit          saw_stall = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_flags;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    if (!rst) begin
      if (held) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_result", bus.out_result, held_res);
        chk("stall_flags", 32'(bus.out_flags), 32'(held_flags));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", bus.out_result, e.res);
          chk("flags", 32'(bus.out_flags), 32'(e.fl));
          chk("mode", 32'(bus.out_mode), 32'(e.mode));
          if (e.lat) chk("latency", 32'(cyc - 1 - e.acc_cyc), 32'd3);
        end
      end
      if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        acc = 1'b1;
        e = pend;
        e.acc_cyc = cyc;
        sb.push_back(e);
      end
      held       = bus.out_valid && !bus.out_ready;
      held_res   = bus.out_result;
      held_flags = bus.out_flags;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.out_ready = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);
  endtask

  task automatic send(input bit m, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [4:0] fl, input bit lat);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_a     = a;
    bus.in_b     = b;
    pend = '{mode: m, res: res, fl: fl, acc_cyc: 0, lat: lat};
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick(acc);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    repeat (3) tick(acc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'h0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_out_mode", 32'(bus.out_mode), 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic products and first-result latency
    send(1'b0, 32'h0000_3E00, 32'h0000_4000, 32'h0000_4200, 5'b00000, 1'b1);
    drain();
    send(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5'b00000, 1'b0);
    send(1'b1, 32'h3F80_0001, 32'h3FC0_0000, E_RND_S,       5'b00010, 1'b0);
    send(1'b0, 32'h0000_3C01, 32'h0000_3E00, E_RND_H,       5'b00010, 1'b0);
    drain();

    // Overflow, underflow and special values
    send(1'b1, 32'h7F00_0000, 32'h7F00_0000, E_OVF_S,       5'b01010, 1'b0);
    send(1'b1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 5'b00110, 1'b0);
    send(1'b0, 32'h0000_7800, 32'h0000_7800, E_OVF_H,       5'b01010, 1'b0);
    send(1'b1, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 5'b10001, 1'b0);
    send(1'b0, 32'h0000_FC00, 32'h0000_4000, 32'h0000_FC00, 5'b00000, 1'b0);
    send(1'b1, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10001, 1'b0);
    send(1'b0, 32'h0000_7E00, 32'h0000_3C00, 32'h0000_7E00, 5'b00001, 1'b0);
    send(1'b0, 32'h0000_8000, 32'h0000_3C00, 32'h0000_8000, 5'b00000, 1'b0);
    drain();

    // Mixed-mode stream with a 4-cycle output stall
    saw_stall  = 1'b0;
    stall_from = cyc + 5;
    stall_len  = 4;
    send(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5'b00000, 1'b0);
    send(1'b0, 32'h0000_3E00, 32'h0000_4000, 32'h0000_4200, 5'b00000, 1'b0);
    send(1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000, 1'b0);
    send(1'b0, 32'h0000_4400, 32'h0000_4200, 32'h0000_4A00, 5'b00000, 1'b0);
    send(1'b1, 32'hBF80_0000, 32'h4000_0000, 32'hC000_0000, 5'b00000, 1'b0);
    send(1'b0, 32'h0000_3C00, 32'h0000_BC00, 32'h0000_BC00, 5'b00000, 1'b0);
    drain();
    chk("stall_in_ready_dropped", 32'(saw_stall), 32'd1);
    stall_len = 0;

    // Reset with three operations in flight
    send(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 5'b00000, 1'b0);
    send(1'b0, 32'h0000_3E00, 32'h0000_4000, 32'h0000_4200, 5'b00000, 1'b0);
    send(1'b1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000, 1'b0);
    rst = 1'b1;
    tick(acc);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    rst  = 1'b0;
    sb.delete();
    held = 1'b0;
    repeat (6) tick(acc);
    chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
    send(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 5'b00000, 1'b1);
    send(1'b0, 32'h0000_4000, 32'h0000_4000, 32'h0000_4400, 5'b00000, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
